// File: rtl/gat_stage_scheduler.sv
// Sequences the SPMM -> DMVM -> SM -> AGGR stages of a GAT accelerator over
// NUM_LAYERS layers, with a per-stage watchdog and a busy-cycle run counter.
module gat_stage_scheduler #(
    parameter int NUM_LAYERS = 2,
    parameter int TIMEOUT    = 16777215
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        spmm_vld_o,
    output logic        dmvm_vld_o,
    output logic        sm_vld_o,
    output logic        aggr_vld_o,
    input  logic        spmm_rdy_i,
    input  logic        dmvm_rdy_i,
    input  logic        sm_rdy_i,
    input  logic        aggr_rdy_i,
    output logic [1:0]  layer_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_stage_o,
    output logic [31:0] total_cyc_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPMM,
        S_DMVM,
        S_SM,
        S_AGGR,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0]  LAST_LAYER = 2'(NUM_LAYERS - 1);
    localparam logic [23:0] WD_LIMIT   = 24'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [23:0] wd_cnt, wd_next;
    logic [31:0] run_cnt, run_next, run_inc;
    logic [31:0] total_next;
    logic [1:0]  layer_next, err_stage_next;
    logic        stage_rdy;
    logic [1:0]  stage_code;

    assign run_inc = (run_cnt == 32'hFFFF_FFFF) ? run_cnt : run_cnt + 32'd1;

    // Only the rdy of the stage currently being driven is honoured.
    always_comb begin
        stage_rdy  = 1'b0;
        stage_code = 2'd0;
        case (state)
            S_SPMM: begin stage_rdy = spmm_rdy_i; stage_code = 2'd0; end
            S_DMVM: begin stage_rdy = dmvm_rdy_i; stage_code = 2'd1; end
            S_SM:   begin stage_rdy = sm_rdy_i;   stage_code = 2'd2; end
            S_AGGR: begin stage_rdy = aggr_rdy_i; stage_code = 2'd3; end
            default: ;
        endcase
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next     = state;
        wd_next        = wd_cnt;
        run_next       = run_cnt;
        total_next     = total_cyc_o;
        layer_next     = layer_o;
        err_stage_next = err_stage_o;

        if (abort_i) begin
            state_next     = S_IDLE;
            wd_next        = '0;
            layer_next     = '0;
            err_stage_next = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state_next = S_SPMM;
                        wd_next    = '0;
                        run_next   = '0;
                        layer_next = '0;
                    end
                end
                S_SPMM, S_DMVM, S_SM, S_AGGR: begin
                    run_next = run_inc;
                    // A completion in the expiry cycle still advances normally.
                    if (stage_rdy) begin
                        wd_next = '0;
                        case (state)
                            S_SPMM: state_next = S_DMVM;
                            S_DMVM: state_next = S_SM;
                            S_SM:   state_next = S_AGGR;
                            default: begin
                                if (layer_o < LAST_LAYER) begin
                                    layer_next = layer_o + 2'd1;
                                    state_next = S_SPMM;
                                end else begin
                                    state_next = S_DONE;
                                    total_next = run_inc;
                                end
                            end
                        endcase
                    end else if (wd_cnt == WD_LIMIT) begin
                        state_next     = S_ERR;
                        err_stage_next = stage_code;
                    end else begin
                        wd_next = wd_cnt + 24'd1;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: ;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments; outputs are decoded from
    // state_next so they are registered and line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wd_cnt      <= '0;
            run_cnt     <= '0;
            total_cyc_o <= '0;
            layer_o     <= '0;
            err_stage_o <= '0;
            spmm_vld_o  <= 1'b0;
            dmvm_vld_o  <= 1'b0;
            sm_vld_o    <= 1'b0;
            aggr_vld_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_next;
            wd_cnt      <= wd_next;
            run_cnt     <= run_next;
            total_cyc_o <= total_next;
            layer_o     <= layer_next;
            err_stage_o <= err_stage_next;
            spmm_vld_o  <= (state_next == S_SPMM);
            dmvm_vld_o  <= (state_next == S_DMVM);
            sm_vld_o    <= (state_next == S_SM);
            aggr_vld_o  <= (state_next == S_AGGR);
            busy_o      <= (state_next == S_SPMM) || (state_next == S_DMVM) ||
                           (state_next == S_SM)   || (state_next == S_AGGR);
            done_o      <= (state_next == S_DONE);
            err_o       <= (state_next == S_ERR);
        end
    end

endmodule

// File: tb/tb_gat_stage_scheduler.sv
// Directed bench for gat_stage_scheduler with NUM_LAYERS=2, TIMEOUT=16.
module tb_gat_stage_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i;
    logic        spmm_vld_o, dmvm_vld_o, sm_vld_o, aggr_vld_o;
    logic        spmm_rdy_i, dmvm_rdy_i, sm_rdy_i, aggr_rdy_i;
    logic [1:0]  layer_o;
    logic        busy_o, done_o, err_o;
    logic [1:0]  err_stage_o;
    logic [31:0] total_cyc_o;

    int n_cmp = 0;
    int n_bad = 0;

    gat_stage_scheduler #(.NUM_LAYERS(2), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .spmm_vld_o  (spmm_vld_o),
        .dmvm_vld_o  (dmvm_vld_o),
        .sm_vld_o    (sm_vld_o),
        .aggr_vld_o  (aggr_vld_o),
        .spmm_rdy_i  (spmm_rdy_i),
        .dmvm_rdy_i  (dmvm_rdy_i),
        .sm_rdy_i    (sm_rdy_i),
        .aggr_rdy_i  (aggr_rdy_i),
        .layer_o     (layer_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .err_stage_o (err_stage_o),
        .total_cyc_o (total_cyc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] vld();
        return {spmm_vld_o, dmvm_vld_o, sm_vld_o, aggr_vld_o};
    endfunction

    // Checks the active stage, then completes it after len cycles in the stage.
    task automatic run_stage(input logic [3:0] exp_vld, input logic [1:0] exp_layer, input int len);
        check("stage_vld", 32'(vld()), 32'(exp_vld));
        check("stage_layer", 32'(layer_o), 32'(exp_layer));
        check("stage_busy", 32'(busy_o), 32'd1);
        repeat (len - 1) tick();
        {spmm_rdy_i, dmvm_rdy_i, sm_rdy_i, aggr_rdy_i} = exp_vld;
        tick();
        {spmm_rdy_i, dmvm_rdy_i, sm_rdy_i, aggr_rdy_i} = 4'b0000;
    endtask

    task automatic full_run(input int len);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int l = 0; l < 2; l++)
            for (int s = 0; s < 4; s++)
                run_stage(4'b1000 >> s, 2'(l), len);
        check("done_pulse", 32'(done_o), 32'd1);
        check("done_busy", 32'(busy_o), 32'd0);
        check("done_vld", 32'(vld()), 32'd0);
        check("total_cyc", total_cyc_o, 32'(8 * len));
        tick();
        check("done_one_cycle", 32'(done_o), 32'd0);
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        {spmm_rdy_i, dmvm_rdy_i, sm_rdy_i, aggr_rdy_i} = 4'b0000;
        tick();
        tick();
        rst = 1'b0;

        check("rst_vld", 32'(vld()), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_layer", 32'(layer_o), 32'd0);
        check("rst_total", total_cyc_o, 32'd0);

        // Nominal two-layer run, 3 cycles per stage.
        full_run(3);

        // SPMM watchdog timeout.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (15) tick();
        check("wd_cycle16_vld", 32'(vld()), 32'b1000);
        check("wd_cycle16_err", 32'(err_o), 32'd0);
        tick();
        check("wd_err", 32'(err_o), 32'd1);
        check("wd_err_stage", 32'(err_stage_o), 32'd0);
        check("wd_vld", 32'(vld()), 32'd0);
        check("wd_busy", 32'(busy_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("err_ignores_start", 32'(err_o), 32'd1);
        check("err_ignores_start_vld", 32'(vld()), 32'd0);
        do_abort();
        check("abort_clr_err", 32'(err_o), 32'd0);
        check("abort_clr_stage", 32'(err_stage_o), 32'd0);
        check("err_keeps_total", total_cyc_o, 32'd24);

        // rdy in the expiry cycle of SM wins.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        run_stage(4'b1000, 2'd0, 1);
        run_stage(4'b0100, 2'd0, 1);
        repeat (15) tick();
        check("sm_expiry_vld", 32'(vld()), 32'b0010);
        sm_rdy_i = 1'b1;
        tick();
        sm_rdy_i = 1'b0;
        check("sm_race_vld", 32'(vld()), 32'b0001);
        check("sm_race_err", 32'(err_o), 32'd0);
        do_abort();
        check("abort_idle_vld", 32'(vld()), 32'd0);
        check("abort_idle_layer", 32'(layer_o), 32'd0);

        // DMVM timeout reports stage 1.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        run_stage(4'b1000, 2'd0, 1);
        repeat (16) tick();
        check("dmvm_to_err", 32'(err_o), 32'd1);
        check("dmvm_to_stage", 32'(err_stage_o), 32'd1);
        do_abort();

        // Foreign rdy and mid-run start are ignored.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        dmvm_rdy_i = 1'b1;
        aggr_rdy_i = 1'b1;
        tick();
        dmvm_rdy_i = 1'b0;
        aggr_rdy_i = 1'b0;
        check("foreign_rdy_vld", 32'(vld()), 32'b1000);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("midrun_start_vld", 32'(vld()), 32'b1000);
        check("midrun_start_layer", 32'(layer_o), 32'd0);
        do_abort();

        // abort beats spmm_rdy in the same cycle.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b1;
        spmm_rdy_i = 1'b1;
        tick();
        abort_i = 1'b0;
        spmm_rdy_i = 1'b0;
        check("abort_rdy_vld", 32'(vld()), 32'd0);
        check("abort_rdy_busy", 32'(busy_o), 32'd0);
        tick();
        tick();
        check("abort_rdy_no_dmvm", 32'(dmvm_vld_o), 32'd0);
        check("abort_keeps_total", total_cyc_o, 32'd24);

        // Reset in layer-1 DMVM, then a fresh run with 1-cycle stages.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int s = 0; s < 4; s++)
            run_stage(4'b1000 >> s, 2'd0, 1);
        run_stage(4'b1000, 2'd1, 1);
        check("l1_dmvm_vld", 32'(vld()), 32'b0100);
        check("l1_dmvm_layer", 32'(layer_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_vld", 32'(vld()), 32'd0);
        check("midrst_layer", 32'(layer_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_total", total_cyc_o, 32'd0);
        check("midrst_err", 32'(err_o), 32'd0);
        full_run(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
